dcache_port_arbiter: RTL and testbench
======================================

Name: dcache_port_arbiter

Overview:
- Shares the single data-cache request port between NumPorts requesters: PTW (port 0), load unit (port 1), store unit (port 2).
- Round-robin grant; a granted request is held stable until downstream accepts it.
- Tracks outstanding transactions in an in-order FIFO of port indices and routes each response back to its originator.
- Sits between the MMU/load-store unit and the write-through data cache.

Parameters:
- NumPorts, 3, number of requesters (2..8)
- AddrWidth, 64, request address width (matches AXI address width)
- DataWidth, 64, read/write data width (matches AXI data width)
- MaxOutstanding, 7, maximum accepted-but-unanswered transactions (matches max outstanding stores)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- port_req_i  in  NumPorts  per-port request valid
- port_ready_o  out  NumPorts  per-port request accepted this cycle
- port_addr_i  in  NumPorts*AddrWidth  per-port address, port p at [p*AddrWidth +: AddrWidth]
- port_wdata_i  in  NumPorts*DataWidth  per-port write data
- port_be_i  in  NumPorts*(DataWidth/8)  per-port byte enables
- port_we_i  in  NumPorts  per-port write enable
- port_rsp_valid_o  out  NumPorts  one-hot response strobe
- port_rsp_rdata_o  out  DataWidth  response data, broadcast to all ports
- req_valid_o  out  1  downstream request valid
- req_ready_i  in  1  downstream accepts request
- req_addr_o  out  AddrWidth  selected address
- req_wdata_o  out  DataWidth  selected write data
- req_be_o  out  DataWidth/8  selected byte enables
- req_we_o  out  1  selected write enable
- req_port_o  out  $clog2(NumPorts)  index of granted port
- rsp_valid_i  in  1  downstream response; responses arrive strictly in request order
- rsp_rdata_i  in  DataWidth  response data
- busy_o  out  1  outstanding count != 0
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values: req_valid_o=0, port_ready_o=0, port_rsp_valid_o=0, busy_o=0, err_o=0. Round-robin pointer=0, outstanding count=0, FIFO empty, lock cleared.
- States:
  - IDLE: no lock held.
  - LOCKED: a grant is presented downstream and held.
- IDLE behaviour:
  - Arbitration is combinational.
  - Search begins at pointer, ascending modulo NumPorts; first asserted port_req_i wins.
  - A winner is only presented when count < MaxOutstanding. At count == MaxOutstanding nothing is granted, even if a response retires in the same cycle (no bypass).
  - With a winner: req_valid_o=1 and the winner's payload is muxed out in the same cycle (0-cycle latency).
  - If req_ready_i=0, the winner index is latched and the next state is LOCKED.
- LOCKED behaviour:
  - req_valid_o stays 1 and the latched port's payload is muxed.
  - The requester must hold its request and payload stable; if port_req_i drops while locked, set err_o and keep presenting.
  - No re-arbitration while locked.
- Acceptance (req_valid_o & req_ready_i):
  - port_ready_o[granted]=1 that cycle.
  - Granted index is pushed into the FIFO.
  - Pointer becomes (granted+1) mod NumPorts.
  - Lock is cleared and the state returns to IDLE.
  - Next arbitration happens the following cycle; at most one grant per cycle.
- Response (rsp_valid_i):
  - Pop the FIFO head h; port_rsp_valid_o[h]=1 and port_rsp_rdata_o=rsp_rdata_i, combinational, 0-cycle latency.
  - There is no response backpressure.
  - Writes also receive exactly one response (ack).
- rsp_valid_i with an empty FIFO: set err_o, drive no port strobe, leave count unchanged.
- Simultaneous push and pop: count unchanged, FIFO head advances, tail writes.
- FIFO is a circular buffer of MaxOutstanding entries. Read and write pointers wrap from MaxOutstanding-1 to 0 (non-power-of-two wrap is explicit). Count width is $clog2(MaxOutstanding+1).
- err_o is sticky and cleared only by reset.
- Reset mid-operation: lock, FIFO and count are cleared. The downstream cache is reset by the same rst_i, so no stale responses are expected.

Decomposition:
- Shared package dcache_arb_pkg holds:
  - port_idx_t (logic [$clog2(NumPorts)-1:0])
  - PortPtw=0, PortLoad=1, PortStore=2 constants
  - arb_state_e {IDLE, LOCKED}
- One sub-module, arb_id_fifo: parameterised depth/width circular FIFO with push/pop/full/empty/count and same-cycle push+pop support.
- Arbiter logic stays in the top module.

Test Plan:
- Ports 0,1,2 requesting continuously, req_ready_i=1, one response per cycle 1 cycle later -> grants in order 0,1,2,0,1,2; port_rsp_valid_o one-hot follows the same order.
- Port 1 requests, req_ready_i low for 3 cycles -> req_valid_o held 4 cycles with constant addr 0x8000_0040; port 2 raising meanwhile is not granted; port_ready_o[1] pulses only in cycle 4.
- 7 accepted requests with no responses -> count=7, req_valid_o=0 despite pending requests; one rsp_valid_i -> next cycle a grant is issued.
- Push and pop in the same cycle with count=3 -> count stays 3, routing correct across the FIFO wrap at entry 6->0.
- rsp_valid_i with empty FIFO -> err_o=1 and sticky, no port strobe; rst_i clears it.
- rst_i asserted while LOCKED with count=4 -> next cycle all outputs are at reset values and arbitration restarts at port 0.

Source files
------------

// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - shared types and port indices for the data-cache port arbiter
package dcache_arb_pkg;

    localparam int DefaultNumPorts = 3;

    typedef logic [$clog2(DefaultNumPorts)-1:0] port_idx_t;

    localparam port_idx_t PortPtw   = 2'd0;
    localparam port_idx_t PortLoad  = 2'd1;
    localparam port_idx_t PortStore = 2'd2;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - circular FIFO of requester indices with same-cycle push and pop
module arb_id_fifo #(
    parameter int Depth = 7,
    parameter int Width = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - round-robin sharing of the data-cache port with in-order response routing
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int NumPorts       = 3,
    parameter int AddrWidth      = 64,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 7
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumPorts-1:0]               port_req_i,
    output logic [NumPorts-1:0]               port_ready_o,
    input  logic [NumPorts*AddrWidth-1:0]     port_addr_i,
    input  logic [NumPorts*DataWidth-1:0]     port_wdata_i,
    input  logic [NumPorts*(DataWidth/8)-1:0] port_be_i,
    input  logic [NumPorts-1:0]               port_we_i,
    output logic [NumPorts-1:0]               port_rsp_valid_o,
    output logic [DataWidth-1:0]              port_rsp_rdata_o,
    output logic                              req_valid_o,
    input  logic                              req_ready_i,
    output logic [AddrWidth-1:0]              req_addr_o,
    output logic [DataWidth-1:0]              req_wdata_o,
    output logic [DataWidth/8-1:0]            req_be_o,
    output logic                              req_we_o,
    output logic [$clog2(NumPorts)-1:0]       req_port_o,
    input  logic                              rsp_valid_i,
    input  logic [DataWidth-1:0]              rsp_rdata_i,
    output logic                              busy_o,
    output logic                              err_o
);

    localparam int IdxW = $clog2(NumPorts);
    localparam int BeW  = DataWidth / 8;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    arb_state_e      state_q;
    logic [IdxW-1:0] lock_idx_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] sel_idx;
    logic [IdxW-1:0] head_idx;
    logic            win_found;
    logic            accept;
    logic            rsp_hit;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            err_q;

    // Search starts at the round-robin pointer and wraps modulo NumPorts.
    always_comb begin
        int c;
        win_found = 1'b0;
        win_idx   = '0;
        c         = 0;
        for (int k = 0; k < NumPorts; k++) begin
            c = int'(rr_ptr_q) + k;
            if (c >= NumPorts) c = c - NumPorts;
            if (!win_found && port_req_i[c]) begin
                win_found = 1'b1;
                win_idx   = IdxW'(c);
            end
        end
    end

    // A full tracker blocks new grants even if a response retires this cycle.
    assign sel_idx     = (state_q == LOCKED) ? lock_idx_q : win_idx;
    assign req_valid_o = !rst_i && ((state_q == LOCKED) || (win_found && !fifo_full));
    assign req_port_o  = sel_idx;
    assign accept      = req_valid_o && req_ready_i;
    assign rsp_hit     = !rst_i && rsp_valid_i && !fifo_empty;

    always_comb begin
        req_addr_o  = '0;
        req_wdata_o = '0;
        req_be_o    = '0;
        req_we_o    = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            if (sel_idx == IdxW'(p)) begin
                req_addr_o  = port_addr_i[p*AddrWidth +: AddrWidth];
                req_wdata_o = port_wdata_i[p*DataWidth +: DataWidth];
                req_be_o    = port_be_i[p*BeW +: BeW];
                req_we_o    = port_we_i[p];
            end
        end
    end

    always_comb begin
        port_ready_o     = '0;
        port_rsp_valid_o = '0;
        for (int p = 0; p < NumPorts; p++) begin
            port_ready_o[p]     = accept && (sel_idx == IdxW'(p));
            port_rsp_valid_o[p] = rsp_hit && (head_idx == IdxW'(p));
        end
    end

    assign port_rsp_rdata_o = rsp_rdata_i;
    assign busy_o           = (fifo_count != '0);
    assign err_o            = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (rsp_valid_i && fifo_empty) err_q <= 1'b1;
            if (state_q == LOCKED && !port_req_i[lock_idx_q]) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (req_valid_o && !req_ready_i) begin
                        state_q    <= LOCKED;
                        lock_idx_q <= win_idx;
                    end
                end
                LOCKED: begin
                    if (req_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (accept) begin
                rr_ptr_q <= (sel_idx == IdxW'(NumPorts - 1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (sel_idx),
        .pop_i       (rsp_hit),
        .head_o      (head_idx),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - randomized and directed checks of dcache_port_arbiter against a queue model
module tb_dcache_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MO = 7;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NP-1:0]     port_req_i;
    logic [NP-1:0]     port_ready_o;
    logic [NP*AW-1:0]  port_addr_i;
    logic [NP*DW-1:0]  port_wdata_i;
    logic [NP*8-1:0]   port_be_i;
    logic [NP-1:0]     port_we_i;
    logic [NP-1:0]     port_rsp_valid_o;
    logic [DW-1:0]     port_rsp_rdata_o;
    logic              req_valid_o;
    logic              req_ready_i;
    logic [AW-1:0]     req_addr_o;
    logic [DW-1:0]     req_wdata_o;
    logic [7:0]        req_be_o;
    logic              req_we_o;
    logic [1:0]        req_port_o;
    logic              rsp_valid_i;
    logic [DW-1:0]     rsp_rdata_i;
    logic              busy_o;
    logic              err_o;

    logic [AW-1:0] addr_in  [NP];
    logic [DW-1:0] wdata_in [NP];
    logic [7:0]    be_in    [NP];
    logic          we_in    [NP];
    logic          req_in   [NP];

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < NP; p++) begin
            port_req_i[p]            = req_in[p];
            port_addr_i[p*AW +: AW]  = addr_in[p];
            port_wdata_i[p*DW +: DW] = wdata_in[p];
            port_be_i[p*8 +: 8]      = be_in[p];
            port_we_i[p]             = we_in[p];
        end
    end

    dcache_port_arbiter #(
        .NumPorts       (NP),
        .AddrWidth      (AW),
        .DataWidth      (DW),
        .MaxOutstanding (MO)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .port_req_i       (port_req_i),
        .port_ready_o     (port_ready_o),
        .port_addr_i      (port_addr_i),
        .port_wdata_i     (port_wdata_i),
        .port_be_i        (port_be_i),
        .port_we_i        (port_we_i),
        .port_rsp_valid_o (port_rsp_valid_o),
        .port_rsp_rdata_o (port_rsp_rdata_o),
        .req_valid_o      (req_valid_o),
        .req_ready_i      (req_ready_i),
        .req_addr_o       (req_addr_o),
        .req_wdata_o      (req_wdata_o),
        .req_be_o         (req_be_o),
        .req_we_o         (req_we_o),
        .req_port_o       (req_port_o),
        .rsp_valid_i      (rsp_valid_i),
        .rsp_rdata_i      (rsp_rdata_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: outstanding port ids in arrival order, rotating priority, held grant.
    int m_q[$];
    int m_ptr  = 0;
    int m_held = -1;
    bit m_err  = 1'b0;

    int e_g;
    bit e_valid;
    bit e_accept;
    int e_strobe;
    int last_accept;

    logic          s_valid;
    logic [1:0]    s_port;
    logic [NP-1:0] s_ready;
    logic [NP-1:0] s_strobe;
    logic [AW-1:0] s_addr;
    logic          s_busy;
    logic          s_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set at the falling edge; compare 1 time unit later, then advance one clock.
    task automatic step();
        #1;
        e_valid  = 1'b0;
        e_g      = 0;
        e_strobe = -1;
        if (!rst_i) begin
            if (m_held >= 0) begin
                e_valid = 1'b1;
                e_g     = m_held;
            end else if (m_q.size() < MO) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (m_ptr + k) % NP;
                    if (!e_valid && req_in[p]) begin
                        e_valid = 1'b1;
                        e_g     = p;
                    end
                end
            end
            if (rsp_valid_i && m_q.size() > 0) e_strobe = m_q[0];
        end
        e_accept = e_valid && req_ready_i;

        s_valid  = req_valid_o;
        s_port   = req_port_o;
        s_ready  = port_ready_o;
        s_strobe = port_rsp_valid_o;
        s_addr   = req_addr_o;
        s_busy   = busy_o;
        s_err    = err_o;

        check("req_valid", 64'(req_valid_o), 64'(e_valid));
        if (e_valid) begin
            check("req_port", 64'(req_port_o), 64'(e_g));
            check("req_addr", req_addr_o, addr_in[e_g]);
            check("req_wdata", req_wdata_o, wdata_in[e_g]);
            check("req_be", 64'(req_be_o), 64'(be_in[e_g]));
            check("req_we", 64'(req_we_o), 64'(we_in[e_g]));
        end
        check("port_ready", 64'(port_ready_o), e_accept ? (64'd1 << e_g) : 64'd0);
        check("rsp_strobe", 64'(port_rsp_valid_o), (e_strobe >= 0) ? (64'd1 << e_strobe) : 64'd0);
        if (e_strobe >= 0) check("rsp_rdata", port_rsp_rdata_o, rsp_rdata_i);
        check("busy", 64'(busy_o), 64'(m_q.size() != 0));
        check("err", 64'(err_o), 64'(m_err));

        @(posedge clk);
        if (rst_i) begin
            m_q.delete();
            m_ptr  = 0;
            m_held = -1;
            m_err  = 1'b0;
        end else begin
            if (rsp_valid_i && m_q.size() == 0) m_err = 1'b1;
            if (m_held >= 0 && !req_in[m_held]) m_err = 1'b1;
            if (e_strobe >= 0) void'(m_q.pop_front());
            if (e_accept) begin
                m_q.push_back(e_g);
                m_ptr  = (e_g + 1) % NP;
                m_held = -1;
            end else if (e_valid) begin
                m_held = e_g;
            end
        end
        last_accept = e_accept ? e_g : -1;
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic on);
        req_in[p]   = on;
        addr_in[p]  = {$urandom, $urandom};
        wdata_in[p] = {$urandom, $urandom};
        be_in[p]    = 8'($urandom);
        we_in[p]    = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        for (int p = 0; p < NP; p++) req_in[p] = 1'b0;
        step();
        check("rst_valid", 64'(s_valid), 64'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_rdata_i = '0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_req_valid", 64'(req_valid_o), 64'd0);
        check("reset_port_ready", 64'(port_ready_o), 64'd0);
        check("reset_rsp_strobe", 64'(port_rsp_valid_o), 64'd0);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        @(negedge clk);
        do_reset();

        // Continuous requests on all ports, each answered one cycle after acceptance.
        for (int p = 0; p < NP; p++) set_port(p, 1'b1);
        req_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rsp_valid_i = (m_q.size() > 0);
            rsp_rdata_i = {$urandom, $urandom};
            step();
            check("rr_order", 64'(s_port), 64'(i % 3));
            if (i > 0) check("rsp_order", 64'(s_strobe), 64'd1 << ((i - 1) % 3));
        end

        // Held grant under backpressure; a late requester must wait.
        do_reset();
        set_port(1, 1'b1);
        addr_in[1] = 64'h8000_0040;
        for (int i = 0; i < 4; i++) begin
            req_ready_i = (i == 3);
            if (i == 1) set_port(2, 1'b1);
            step();
            check("hold_valid", 64'(s_valid), 64'd1);
            check("hold_port", 64'(s_port), 64'd1);
            check("hold_addr", s_addr, 64'h8000_0040);
            check("hold_ready", 64'(s_ready), (i == 3) ? 64'd2 : 64'd0);
        end
        req_in[1] = 1'b0;
        step();
        check("late_port", 64'(s_port), 64'd2);

        // Tracker full: no grant until a response retires, and not in that same cycle.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1);
        req_ready_i = 1'b1;
        for (int i = 0; i < MO; i++) step();
        step();
        check("full_block", 64'(s_valid), 64'd0);
        rsp_valid_i = 1'b1;
        step();
        check("full_no_bypass", 64'(s_valid), 64'd0);
        rsp_valid_i = 1'b0;
        step();
        check("full_regrant", 64'(s_valid), 64'd1);

        // Random traffic exercises concurrent push/pop and pointer wrap.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (last_accept == p) req_in[p] = 1'b0;
                else if (!req_in[p] && ($urandom % 2 == 0)) set_port(p, 1'b1);
            end
            req_ready_i = ($urandom % 4 != 0);
            rsp_valid_i = (m_q.size() > 0) && ($urandom % 3 != 0);
            rsp_rdata_i = {$urandom, $urandom};
            step();
        end

        // Response with nothing outstanding raises a sticky error.
        do_reset();
        rsp_valid_i = 1'b1;
        step();
        check("orphan_strobe", 64'(s_strobe), 64'd0);
        rsp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_sticky", 64'(s_err), 64'd1);
        end
        do_reset();
        step();
        check("err_cleared", 64'(s_err), 64'd0);

        // Dropping a held request is a protocol error.
        set_port(0, 1'b1);
        req_ready_i = 1'b0;
        step();
        req_in[0] = 1'b0;
        step();
        step();
        check("drop_err", 64'(s_err), 64'd1);

        // Reset while locked with four outstanding.
        do_reset();
        for (int p = 0; p < NP; p++) set_port(p, 1'b1);
        req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();
        req_ready_i = 1'b0;
        step();
        check("pre_rst_busy", 64'(s_busy), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        check("post_rst_port", 64'(s_port), 64'd0);
        check("post_rst_busy", 64'(s_busy), 64'd0);
        check("post_rst_ready", 64'(s_ready), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
